// File: rtl/grid_selector.sv
// grid_selector
//   Moves a cursor over a COLS x ROWS grid from four debounced direction
//   buttons. Optional edge wrap, hold-to-repeat (delay then period),
//   synchronous home, and a one-cycle strobe after every index change.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   btn_up     debounced level, high = held (highest priority)
//   btn_down   debounced level
//   btn_left   debounced level
//   btn_right  debounced level (lowest priority)
//   home       synchronous return to RESET_INDEX, overrides all steps
//   index      selected cell, row*COLS + col
//   row        cursor row, 0 = top
//   col        cursor column, 0 = left
//   changed    one-cycle pulse in the cycle after index takes a new value
module grid_selector #(
  parameter int COLS          = 3,
  parameter int ROWS          = 3,
  parameter int RESET_INDEX   = 4,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1,
  parameter int IW            = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1,
  localparam int RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          home,
  output logic [IW-1:0] index,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          changed
);

  localparam int MAXRC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW  = (MAXRC > 0) ? $clog2(MAXRC + 1) : 1;

  localparam logic [RW-1:0]   RST_ROW  = RW'(RESET_INDEX / COLS);
  localparam logic [CW-1:0]   RST_COL  = CW'(RESET_INDEX % COLS);
  localparam logic [IW-1:0]   RST_IDX  = IW'(RESET_INDEX);
  localparam logic [RW-1:0]   ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_MAX  = CW'(COLS - 1);
  localparam logic [IW-1:0]   COLS_IW  = IW'(COLS);
  localparam logic [CNTW-1:0] DLY_LOAD = CNTW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNTW-1:0] PER_LOAD = CNTW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [3:0]      r_prev;
  logic [3:0]      r_held;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [IW-1:0]   r_index;
  logic            r_changed;

  // Button vector, bit 3 = up ... bit 0 = right, so higher bit = higher priority.
  logic [3:0]    w_btn;
  logic [3:0]    w_press;
  logic [3:0]    w_press_pri;
  logic [3:0]    w_dir;
  logic          w_held_on;
  logic          w_rep_fire;
  logic [RW-1:0] w_next_row;
  logic [CW-1:0] w_next_col;
  logic [IW-1:0] w_next_index;
  logic          w_moved;

  assign w_btn     = {btn_up, btn_down, btn_left, btn_right};
  assign w_press   = w_btn & ~r_prev;
  assign w_held_on = |(w_btn & r_held);

  always_comb begin
    w_press_pri = '0;
    if (w_press[3])      w_press_pri = 4'b1000;
    else if (w_press[2]) w_press_pri = 4'b0100;
    else if (w_press[1]) w_press_pri = 4'b0010;
    else if (w_press[0]) w_press_pri = 4'b0001;

    w_rep_fire = ((r_state == S_DELAY) || (r_state == S_REPEAT)) && w_held_on && (r_cnt == '0);

    // Only IDLE reacts to new presses; DELAY/REPEAT step only on countdown expiry.
    w_dir = '0;
    if (!home) begin
      if (r_state == S_IDLE) w_dir = w_press_pri;
      else if (w_rep_fire)   w_dir = r_held;
    end

    // Wrap on a 1-wide axis lands back on the same cell, so it reads as no move.
    w_next_row = r_row;
    w_next_col = r_col;
    if (w_dir[3]) begin
      if (r_row != '0)    w_next_row = r_row - RW'(1);
      else if (WRAP != 0) w_next_row = ROW_MAX;
    end else if (w_dir[2]) begin
      if (r_row != ROW_MAX) w_next_row = r_row + RW'(1);
      else if (WRAP != 0)   w_next_row = '0;
    end else if (w_dir[1]) begin
      if (r_col != '0)    w_next_col = r_col - CW'(1);
      else if (WRAP != 0) w_next_col = COL_MAX;
    end else if (w_dir[0]) begin
      if (r_col != COL_MAX) w_next_col = r_col + CW'(1);
      else if (WRAP != 0)   w_next_col = '0;
    end

    w_next_index = IW'(w_next_row) * COLS_IW + IW'(w_next_col);
    w_moved      = (w_next_row != r_row) || (w_next_col != r_col);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_prev    <= '0;
      r_held    <= '0;
      r_row     <= RST_ROW;
      r_col     <= RST_COL;
      r_index   <= RST_IDX;
      r_changed <= 1'b0;
    end else begin
      r_prev <= w_btn;
      if (home) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_held    <= '0;
        r_row     <= RST_ROW;
        r_col     <= RST_COL;
        r_index   <= RST_IDX;
        r_changed <= (r_index != RST_IDX);
      end else begin
        r_row     <= w_next_row;
        r_col     <= w_next_col;
        r_index   <= w_next_index;
        r_changed <= w_moved;
        case (r_state)
          S_IDLE: begin
            if (|w_press) begin
              r_held <= w_press_pri;
              if (REPEAT_DELAY > 0) begin
                r_state <= S_DELAY;
                r_cnt   <= DLY_LOAD;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_DELAY, S_REPEAT: begin
            if (!w_held_on) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == '0) begin
              r_state <= S_REPEAT;
              r_cnt   <= PER_LOAD;
            end else begin
              r_cnt <= r_cnt - CNTW'(1);
            end
          end
          S_HOLD: begin
            if (!w_held_on) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign index   = r_index;
  assign row     = r_row;
  assign col     = r_col;
  assign changed = r_changed;

endmodule

// File: tb/tb_grid_selector.sv
// Randomized bench for grid_selector: three differently-configured instances
// share one stimulus stream and are compared against a cycle-indexed model.
module tb_grid_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, up, dn, lf, rt, home;

  logic [3:0] idx_a; logic [1:0] row_a; logic [1:0] col_a; logic chg_a;
  logic [2:0] idx_b; logic [0:0] row_b; logic [2:0] col_b; logic chg_b;
  logic [3:0] idx_c; logic [1:0] row_c; logic [1:0] col_c; logic chg_c;

  // A: 3x3 blocking edges, no repeat. B: 8x1 wrap, delay 4 / period 2.
  // C: 3x3 wrap, delay 1 / period 3.
  grid_selector #(.COLS(3), .ROWS(3), .RESET_INDEX(4), .WRAP(0),
                  .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) u_a (
    .clk(clk), .resetn(resetn), .btn_up(up), .btn_down(dn), .btn_left(lf),
    .btn_right(rt), .home(home), .index(idx_a), .row(row_a), .col(col_a),
    .changed(chg_a));

  grid_selector #(.COLS(8), .ROWS(1), .RESET_INDEX(0), .WRAP(1),
                  .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) u_b (
    .clk(clk), .resetn(resetn), .btn_up(up), .btn_down(dn), .btn_left(lf),
    .btn_right(rt), .home(home), .index(idx_b), .row(row_b), .col(col_b),
    .changed(chg_b));

  grid_selector #(.COLS(3), .ROWS(3), .RESET_INDEX(4), .WRAP(1),
                  .REPEAT_DELAY(1), .REPEAT_PERIOD(3)) u_c (
    .clk(clk), .resetn(resetn), .btn_up(up), .btn_down(dn), .btn_left(lf),
    .btn_right(rt), .home(home), .index(idx_c), .row(row_c), .col(col_c),
    .changed(chg_c));

  localparam int M_COLS [3] = '{3, 8, 3};
  localparam int M_ROWS [3] = '{3, 1, 3};
  localparam int M_RST  [3] = '{4, 0, 4};
  localparam int M_WRAP [3] = '{0, 1, 1};
  localparam int M_DLY  [3] = '{0, 4, 1};
  localparam int M_PER  [3] = '{1, 2, 3};

  int       m_row  [3];
  int       m_col  [3];
  int       m_held [3];
  int       m_t0   [3];
  bit       m_chg  [3];
  bit [3:0] m_prev [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_row[k]  = M_RST[k] / M_COLS[k];
      m_col[k]  = M_RST[k] % M_COLS[k];
      m_held[k] = -1;
      m_t0[k]   = 0;
      m_chg[k]  = 1'b0;
      m_prev[k] = 4'b0000;
    end
  endtask

  // Steps are scheduled by elapsed cycles since the first step:
  // first step at t0, repeats at t0+D, t0+D+P, t0+D+2P, ...
  task automatic model_edge(input bit [3:0] b, input bit h, input int cyc);
    for (int k = 0; k < 3; k++) begin
      int dir, r, c, e;
      dir = -1;
      r   = m_row[k];
      c   = m_col[k];
      if (h) begin
        r = M_RST[k] / M_COLS[k];
        c = M_RST[k] % M_COLS[k];
        m_held[k] = -1;
      end else if (m_held[k] < 0) begin
        for (int d = 3; d >= 0; d--)
          if (dir < 0 && b[d] && !m_prev[k][d]) dir = d;
        if (dir >= 0) begin
          m_held[k] = dir;
          m_t0[k]   = cyc;
        end
      end else if (!b[m_held[k]]) begin
        m_held[k] = -1;
      end else if (M_DLY[k] > 0) begin
        e = cyc - m_t0[k];
        if (e == M_DLY[k] || (e > M_DLY[k] && (e - M_DLY[k]) % M_PER[k] == 0))
          dir = m_held[k];
      end
      case (dir)
        3: if (r > 0) r = r - 1; else if (M_WRAP[k] != 0) r = M_ROWS[k] - 1;
        2: if (r < M_ROWS[k] - 1) r = r + 1; else if (M_WRAP[k] != 0) r = 0;
        1: if (c > 0) c = c - 1; else if (M_WRAP[k] != 0) c = M_COLS[k] - 1;
        0: if (c < M_COLS[k] - 1) c = c + 1; else if (M_WRAP[k] != 0) c = 0;
        default: ;
      endcase
      m_chg[k]  = (r != m_row[k]) || (c != m_col[k]);
      m_row[k]  = r;
      m_col[k]  = c;
      m_prev[k] = b;
    end
  endtask

  task automatic check_outputs();
    check("a.index",   32'(idx_a), m_row[0] * M_COLS[0] + m_col[0]);
    check("a.row",     32'(row_a), m_row[0]);
    check("a.col",     32'(col_a), m_col[0]);
    check("a.changed", 32'(chg_a), 32'(m_chg[0]));
    check("b.index",   32'(idx_b), m_row[1] * M_COLS[1] + m_col[1]);
    check("b.row",     32'(row_b), m_row[1]);
    check("b.col",     32'(col_b), m_col[1]);
    check("b.changed", 32'(chg_b), 32'(m_chg[1]));
    check("c.index",   32'(idx_c), m_row[2] * M_COLS[2] + m_col[2]);
    check("c.row",     32'(row_c), m_row[2]);
    check("c.col",     32'(col_c), m_col[2]);
    check("c.changed", 32'(chg_c), 32'(m_chg[2]));
  endtask

  initial begin
    int cyc;
    cyc    = 0;
    resetn = 1'b0;
    up = 1'b0; dn = 1'b0; lf = 1'b0; rt = 1'b0; home = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    resetn = 1'b1;

    for (int it = 0; it < 4000; it++) begin
      @(posedge clk);
      cyc++;
      if (resetn) model_edge({up, dn, lf, rt}, home, cyc);
      else        model_reset();
      #1;
      check_outputs();

      @(negedge clk);
      if (!resetn) begin
        resetn = 1'b1;
      end else if (it > 20) begin
        if ($urandom_range(0, 9) == 0) up = ~up;
        if ($urandom_range(0, 9) == 0) dn = ~dn;
        if ($urandom_range(0, 9) == 0) lf = ~lf;
        if ($urandom_range(0, 9) == 0) rt = ~rt;
        home = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 299) == 0) begin
          resetn = 1'b0;
          #1;
          model_reset();
          check_outputs();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_selector.md
# grid_selector

Parametrised successor to the 3x3 pattern selector: moves a cursor over a COLS x ROWS grid from four debounced direction buttons and outputs the selected cell as a linear index plus row/column. Adds optional edge wrap-around, hold-to-repeat with programmable delay and rate, a synchronous home input, and a one-cycle change strobe. Sits between the per-button debouncers (HOLD mode, level outputs) and the pattern generator / menu logic.

## Interface
- COLS, 3: grid columns, >= 1
- ROWS, 3: grid rows, >= 1
- RESET_INDEX, 4: index after reset and on home; must be < COLS*ROWS
- WRAP, 0: 0 = moves at an edge are blocked; 1 = moves wrap to the opposite edge of the same row/column
- REPEAT_DELAY, 0: cycles from first step to first repeat step; 0 disables auto-repeat
- REPEAT_PERIOD, 1: cycles between subsequent repeat steps, >= 1
- IW, $clog2(COLS*ROWS) (min 1): index width, derived

- clk  in  1  system clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- btn_up / btn_down / btn_left / btn_right  in  1 each  debounced level, synchronous to clk, high = held
- home  in  1  synchronous; returns cursor to RESET_INDEX
- index  out  IW  selected cell, row*COLS + col
- row  out  $clog2(ROWS) (min 1)  cursor row, 0 = top
- col  out  $clog2(COLS) (min 1)  cursor column, 0 = left
- changed  out  1  one-cycle pulse in the cycle after index takes a new value

## Operation
- Row and col held in registers; index computed as row*COLS+col (constant multiply, registered with them). No divider.
- Direction priority: up > down > left > right; at most one step per cycle.
- Step rules: up row-1, down row+1, left col-1, right col+1. At an edge: WRAP=0 -> no move, no changed pulse; WRAP=1 -> row 0 up goes to ROWS-1, col COLS-1 right goes to 0, etc. ROWS=1 or COLS=1 with WRAP=1: vertical/horizontal step is a no-op, no changed pulse.
- Press detection: previous button levels registered; a press is a 0->1 transition of any button.
- State machine:
  - IDLE: on any press, step in highest-priority pressed direction, capture it as held direction; go DELAY (REPEAT_DELAY>0) or HOLD (REPEAT_DELAY=0). Buttons already high without a transition cause nothing.
  - DELAY: counter loaded REPEAT_DELAY-1 at step; decrements each cycle. Held direction released -> IDLE. Counter 0 with held still asserted -> step, load REPEAT_PERIOD-1, go REPEAT.
  - REPEAT: same countdown with REPEAT_PERIOD; step at 0 and reload. Release -> IDLE.
  - HOLD: wait for held direction release -> IDLE.
- Other directions pressed while a direction is held are ignored; after return to IDLE, a still-asserted other button does not step until released and pressed again.
- Blocked steps (edge, WRAP=0) still advance the state machine and counter as normal.
- home: highest priority over all steps; sets RESET_INDEX, forces IDLE, pulses changed only if index differs.
- Counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).

## Timing
- Reset (async assert): index=RESET_INDEX, row=RESET_INDEX/COLS, col=RESET_INDEX%COLS (elaboration-time constants), changed=0, state IDLE, counter 0, previous-button registers 0. Deassertion resumes on next edge; a button high at deassertion counts as a press on the first edge (previous register is 0).
- Latency: button first sampled high at edge N -> index/row/col updated at edge N, changed high for cycle N..N+1.
- Held button (REPEAT_DELAY=D>0, REPEAT_PERIOD=P): steps at edges N, N+D, N+D+P, N+D+2P, ... while held.
- Release sampled at edge M: no step at M or later, state IDLE after M, even if counter hits 0 at M.
- home sampled at edge N: index=RESET_INDEX after N; a same-cycle press is discarded.
- Reset mid-DELAY/REPEAT: all state returns to reset values immediately; no residual repeat.

## Test plan
- Reset defaults: hold resetn low -> index=4, row=1, col=1, changed=0; release, no buttons -> unchanged for 20 cycles.
- Blocking, WRAP=0, 3x3: up,up,left,left (each pulsed 1 cycle) from 4 -> index 1,1,0,0; changed pulses only on first up and first left.
- Wrap, WRAP=1, 3x3: from 0 press left -> 2; up -> 8; right -> 6; down -> 0; changed pulses on every step.
- Auto-repeat, COLS=8 ROWS=1 RESET_INDEX=0 DELAY=4 PERIOD=2: hold right from edge 10 to 19 -> index 1@10, 2@14, 3@16, 4@18, stays 4 after release; REPEAT_DELAY=0 same stimulus -> index 1 only.
- Simultaneous: up and right rise same cycle from 4 -> index 1; hold up, pulse left -> no left step; release up with right still high -> no step until right re-pressed -> 2.
- home/reset mid-repeat: during REPEAT assert home -> index=RESET_INDEX, no further steps while still held; assert resetn low mid-DELAY -> index=RESET_INDEX, state IDLE, no step when reset released with button low.
